dc5_upsample_buf: RTL and testbench
===================================

Name: dc5_upsample_buf

Overview:
- 2x nearest-neighbour upsampling stage between the EC-4 encoder output and the DC-5 decoder input.
- Consumes binary feature-map pixel words, one pixel (all channels) per beat, raster order.
- Buffers one row and replays it: each pixel twice horizontally, the whole row twice vertically. Output is 4x the input word count.
- Output uses a valid/ready handshake so DC-5 can stall it.

Parameters:
- DATA_WIDTH, 512, bits per pixel word (one bit per channel).
- ROW_LEN, 8, pixels per input row. Must be >= 2.
- NUM_ROWS, 8, input rows per frame. Must be >= 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle frame start pulse. Honoured only in IDLE.
- data_in  input  DATA_WIDTH  pixel word from EC-4.
- in_en  input  1  data_in valid this cycle.
- in_rdy  output  1  block accepts a word this cycle. High only in FILL.
- data_out  output  DATA_WIDTH  upsampled pixel word to DC-5.
- out_en  output  1  data_out valid. Registered.
- out_rdy  input  1  DC-5 accepts data_out this cycle.
- done  output  1  one-cycle pulse after the last output word of a frame transfers.
- ovf  output  1  one-cycle pulse when in_en=1 while in_rdy=0. The word is dropped.

Behaviour:
- Reset (rst=0, async): state=IDLE; col, dup, pass, row counters = 0; in_rdy=0, out_en=0, data_out=0, done=0, ovf=0. Line buffer contents are don't-care.
- Reset mid-frame aborts immediately. After release the block is in IDLE and waits for start. No partial output is resumed.
- Output transfer rule: a transfer occurs on a cycle with out_en=1 and out_rdy=1.
- FSM states: IDLE, FILL, EMIT, DONE.
- IDLE:
  - start=1 -> FILL, with row=0, col=0.
  - in_en is ignored (ovf pulses).
- FILL:
  - in_rdy=1. Each cycle with in_en=1 writes buf[col]=data_in and increments col.
  - When col reaches ROW_LEN-1 and is written: col=0, dup=0, pass=0, go to EMIT.
  - First output word is presented (out_en=1) the cycle after the last FILL write. Latency from last input accept to first out_en = 1 cycle.
- EMIT:
  - in_rdy=0.
  - Output register loads buf[col] whenever out_en=0 or a transfer occurs, provided words remain. Otherwise out_en holds and data_out is stable while out_rdy=0.
  - Sequence per transfer: dup toggles. When dup goes 1->0, col increments. When col wraps from ROW_LEN-1, pass toggles.
  - After the transfer with pass=1, col=ROW_LEN-1, dup=1, out_en drops next cycle (unless a new word loads) and row increments. No bubble is required, but at most one is allowed.
  - If row was NUM_ROWS-1 -> DONE; else -> FILL with col=0.
  - Per input row, emit 4*ROW_LEN words in order: p0,p0,p1,p1,...,pN-1,pN-1 (pass 0), then the same sequence again (pass 1).
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - out_en=0 in DONE.
- start outside IDLE is ignored with no side effects.
- ovf is independent of state: it pulses on every cycle with in_en=1 and in_rdy=0, and the block otherwise ignores the word.
- out_rdy held low indefinitely: the block stalls losslessly with no timeout. in_rdy stays 0 throughout.
- Frame totals:
  - NUM_ROWS*ROW_LEN input words accepted.
  - 4*NUM_ROWS*ROW_LEN output words.
  - done exactly once.
- Throughput: one output word per cycle when out_rdy is held high.

Test Plan (ROW_LEN=4, NUM_ROWS=2 unless stated):
- Basic frame:
  - Stimulus: start; feed rows A0..A3, B0..B3 back-to-back; out_rdy=1.
  - Required: 32 outputs, exactly A0,A0,A1,A1,A2,A2,A3,A3 twice, then the same pattern for B.
  - Required: first out_en 1 cycle after A3 is accepted; done pulses once, 1 cycle after the last transfer.
- Backpressure:
  - Stimulus: toggle out_rdy in a 1-on/2-off pattern.
  - Required: sequence identical to the basic frame; data_out stable whenever out_en=1 and out_rdy=0; no words lost or duplicated beyond the 4x pattern.
- Overflow:
  - Stimulus: assert in_en during EMIT and during IDLE.
  - Required: ovf pulses on each such cycle; output sequence unchanged; those words never appear at the output.
- Gapped input:
  - Stimulus: in_en high every third cycle during FILL.
  - Required: the buffer captures only valid words; output matches the basic frame.
- Reset mid-EMIT:
  - Stimulus: drop rst during pass 0 of row A.
  - Required: out_en=0 and in_rdy=0 asynchronously; after release, state is IDLE; a new start gives a clean full frame of 32 words.
- Spurious start:
  - Stimulus: pulse start during FILL and during EMIT.
  - Required: no restart, counters unaffected, done still at the end of the original frame.

Source files
------------

// File: rtl/dc5_upsample_buf.sv
// dc5_upsample_buf: 2x nearest-neighbour upsampler between EC-4 and DC-5.
// Captures one input row into a line buffer, then replays it as
// p0,p0,p1,p1,...,pN-1,pN-1 twice (two output rows) over a valid/ready link.
// The counters col/dup/pass always describe the word currently sitting in
// the output register, so the final word of a row is recognised directly.
module dc5_upsample_buf #(
    parameter int DATA_WIDTH = 512,
    parameter int ROW_LEN    = 8,
    parameter int NUM_ROWS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  in_en,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_en,
    input  logic                  out_rdy,
    output logic                  done,
    output logic                  ovf
);

    localparam int COL_W = (ROW_LEN  > 1) ? $clog2(ROW_LEN)  : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  dup_q, dup_d;
    logic                  pass_q, pass_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  out_en_q, out_en_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_en;
    logic [COL_W-1:0]      col_nx;
    logic                  xfer;

    logic [DATA_WIDTH-1:0] line_q [ROW_LEN];

    assign in_rdy   = (state_q == S_FILL);
    assign done     = (state_q == S_DONE);
    assign out_en   = out_en_q;
    assign data_out = data_out_q;
    // Gated by rst so no overflow is flagged while the block is held in reset.
    assign ovf      = rst & in_en & ~in_rdy;
    assign xfer     = out_en_q & out_rdy;

    // Next-state logic: FSM, replay counters and output register loading.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        dup_d      = dup_q;
        pass_d     = pass_q;
        row_d      = row_q;
        out_en_d   = out_en_q;
        data_out_d = data_out_q;
        wr_en      = 1'b0;
        col_nx     = col_q;
        if (dup_q) begin
            col_nx = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_FILL: begin
                if (in_en) begin
                    wr_en = 1'b1;
                    if (col_q == COL_LAST) begin
                        // buf[0] is already valid (ROW_LEN >= 2), so the
                        // first output word is presented on the next cycle.
                        col_d      = '0;
                        dup_d      = 1'b0;
                        pass_d     = 1'b0;
                        state_d    = S_EMIT;
                        out_en_d   = 1'b1;
                        data_out_d = line_q[0];
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (xfer) begin
                    if (pass_q && dup_q && (col_q == COL_LAST)) begin
                        out_en_d = 1'b0;
                        row_d    = row_q + 1'b1;
                        col_d    = '0;
                        dup_d    = 1'b0;
                        pass_d   = 1'b0;
                        state_d  = (row_q == ROW_LAST) ? S_DONE : S_FILL;
                    end else begin
                        dup_d      = ~dup_q;
                        col_d      = col_nx;
                        data_out_d = line_q[col_nx];
                        if (dup_q && (col_q == COL_LAST)) begin
                            pass_d = ~pass_q;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
            end
        endcase
    end

    // State, counters and output register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            dup_q      <= 1'b0;
            pass_q     <= 1'b0;
            row_q      <= '0;
            out_en_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            dup_q      <= dup_d;
            pass_q     <= pass_d;
            row_q      <= row_d;
            out_en_q   <= out_en_d;
            data_out_q <= data_out_d;
        end
    end

    // Line buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_q[col_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_dc5_upsample_buf.sv
// Directed testbench for dc5_upsample_buf (ROW_LEN=4, NUM_ROWS=2, 16-bit words).
module tb_dc5_upsample_buf;

    localparam int DW      = 16;
    localparam int RL      = 4;
    localparam int NR      = 2;
    localparam int IN_TOT  = RL * NR;
    localparam int OUT_TOT = 4 * RL * NR;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] data_in;
    logic          in_en;
    logic          in_rdy;
    logic [DW-1:0] data_out;
    logic          out_en;
    logic          out_rdy;
    logic          done;
    logic          ovf;

    int total  = 0;
    int passed = 0;

    dc5_upsample_buf #(
        .DATA_WIDTH (DW),
        .ROW_LEN    (RL),
        .NUM_ROWS   (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .in_en    (in_en),
        .in_rdy   (in_rdy),
        .data_out (data_out),
        .out_en   (out_en),
        .out_rdy  (out_rdy),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input word i: row base 0xA000, 0xB000, ... plus pixel index.
    function automatic logic [DW-1:0] in_word(input int i);
        return 16'hA000 + 16'(i / RL) * 16'h1000 + 16'(i % RL);
    endfunction

    // Output word n: each row emits p0,p0,p1,p1,.. twice (16 words per row).
    function automatic logic [DW-1:0] out_word(input int n);
        return 16'hA000 + 16'(n / (4 * RL)) * 16'h1000 + 16'((n % (2 * RL)) / 2);
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One frame: gap = input spacing, rdy_mode 0 = always ready / 1 = 1-on-2-off,
    // junk = drive dropped words while not ready, spur = extra start pulses,
    // abort_at >= 0 = assert reset once that many words have transferred.
    task automatic run_frame(input string name, input int gap, input int rdy_mode,
                             input bit junk, input bit spur, input int abort_at);
        int            in_cnt    = 0;
        int            out_cnt   = 0;
        int            cyc       = 0;
        bit            exp_done  = 0;
        bit            done_seen = 0;
        bit            hold      = 0;
        bit            exp_rdy;
        bit            exp_oe;
        bit            feed;
        logic [DW-1:0] held      = '0;

        // Idle cycle before start: optionally an ignored word.
        @(posedge clk); #1;
        start = 1'b0; in_en = junk; data_in = 16'hDEAD; out_rdy = 1'b1;
        @(negedge clk);
        chk_b({name, " idle_in_rdy"}, in_rdy, 1'b0);
        chk_b({name, " idle_ovf"}, ovf, junk);
        chk_b({name, " idle_out_en"}, out_en, 1'b0);

        @(posedge clk); #1;
        start = 1'b1; in_en = 1'b0;
        @(negedge clk);
        chk_b({name, " start_in_rdy"}, in_rdy, 1'b0);

        while (!done_seen && cyc < 600) begin
            @(posedge clk); #1;
            start   = spur && (cyc == 2 || cyc == 9);
            exp_rdy = (in_cnt < IN_TOT) && (out_cnt == 4 * RL * (in_cnt / RL));
            exp_oe  = out_cnt < 4 * RL * (in_cnt / RL);
            feed    = exp_rdy && (cyc % gap == 0);
            in_en   = feed || (junk && !exp_rdy && (cyc % 3 == 1));
            data_in = feed ? in_word(in_cnt) : 16'hDEAD;
            out_rdy = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            @(negedge clk);
            chk_b({name, " in_rdy"}, in_rdy, exp_rdy);
            chk_b({name, " out_en"}, out_en, exp_oe);
            chk_b({name, " ovf"}, ovf, in_en && !exp_rdy);
            chk_b({name, " done"}, done, exp_done);
            if (hold) chk_w({name, " stall_stable"}, data_out, held);
            hold = 0;
            if (exp_done) done_seen = 1;
            exp_done = 0;
            if (feed) in_cnt++;
            if (exp_oe && out_rdy) begin
                chk_w({name, " data_out"}, data_out, out_word(out_cnt));
                out_cnt++;
                if (out_cnt == OUT_TOT) exp_done = 1;
            end else if (exp_oe) begin
                hold = 1;
                held = data_out;
            end
            if (abort_at >= 0 && out_cnt == abort_at) begin
                #2;
                in_en = 1'b1;
                rst   = 1'b0;
                #1;
                chk_b({name, " rst_out_en"}, out_en, 1'b0);
                chk_b({name, " rst_in_rdy"}, in_rdy, 1'b0);
                chk_b({name, " rst_done"}, done, 1'b0);
                chk_b({name, " rst_ovf"}, ovf, 1'b0);
                chk_w({name, " rst_data_out"}, data_out, 16'h0000);
                @(posedge clk); #1;
                rst = 1'b1; in_en = 1'b0; start = 1'b0;
                @(negedge clk);
                chk_b({name, " post_rst_in_rdy"}, in_rdy, 1'b0);
                chk_b({name, " post_rst_out_en"}, out_en, 1'b0);
                $display("frame %s: aborted by reset after %0d outputs", name, out_cnt);
                return;
            end
            cyc++;
        end
        total++;
        if (done_seen) passed++;
        else $error("FAIL %s timeout observed_outputs=%0d expected=%0d", name, out_cnt, OUT_TOT);

        @(posedge clk); #1;
        start = 1'b0; in_en = 1'b0;
        @(negedge clk);
        chk_b({name, " after_done"}, done, 1'b0);
        chk_b({name, " after_in_rdy"}, in_rdy, 1'b0);
        $display("frame %s: in=%0d out=%0d cycles=%0d", name, in_cnt, out_cnt, cyc);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; data_in = '0; in_en = 1'b0; out_rdy = 1'b0;
        #3;
        chk_b("reset in_rdy", in_rdy, 1'b0);
        chk_b("reset out_en", out_en, 1'b0);
        chk_b("reset done", done, 1'b0);
        chk_b("reset ovf", ovf, 1'b0);
        chk_w("reset data_out", data_out, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;

        run_frame("basic",        1, 0, 1'b0, 1'b0, -1);
        run_frame("backpressure", 1, 1, 1'b0, 1'b0, -1);
        run_frame("overflow",     1, 0, 1'b1, 1'b0, -1);
        run_frame("gapped",       3, 0, 1'b0, 1'b0, -1);
        run_frame("reset_emit",   1, 0, 1'b0, 1'b0, 5);
        run_frame("after_reset",  1, 0, 1'b0, 1'b0, -1);
        run_frame("spurious",     1, 0, 1'b0, 1'b1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
